// File: rtl/maxpool_out_packer.sv
// maxpool_out_packer
// Packs the maxpool core's two-copy output beats (full = 2*UNITS words,
// half = UNITS words from copy 0) into dense 2*UNITS-word beats. The packed
// beats are buffered in a small register FIFO with an AXI-stream master port.
// The core cannot be stalled, so s_almost_full warns the controller to drop
// clken early. The FIFO accepts up to two writes per cycle because one
// misaligned full beat that ends a packet flushes two output beats.
//
// Optional build macro: MAXPOOL_OUT_PACKER_OVERFLOW_EN
//   When defined, this adds a sticky overflow flag and a saturating 8-bit
//   drop_count. When undefined, overflow is tied low, and writes to a full
//   FIFO are still discarded without any record.
module maxpool_out_packer #(
  parameter int UNITS      = 8,
  parameter int WORD_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_MARGIN  = 3
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   clken,
  input  logic                                   s_valid,
  input  logic [UNITS-1:0][1:0][WORD_WIDTH-1:0]  s_data_uc,
  input  logic [UNITS-1:0][1:0]                  s_keep_uc,
  input  logic                                   s_last,
  output logic                                   s_almost_full,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [2*UNITS*WORD_WIDTH-1:0]          m_data,
  output logic [2*UNITS-1:0]                     m_keep,
  output logic                                   m_last,
  output logic                                   overflow
);

  localparam int HW = UNITS * WORD_WIDTH;   // bits in one half beat
  localparam int BW = 2 * HW;               // bits in one packed beat
  localparam int KW = 2 * UNITS;            // keep bits per packed beat
  localparam int AW = $clog2(DEPTH);        // FIFO pointer width
  localparam int CW = AW + 1;               // occupancy width, 0..DEPTH

  localparam logic [KW-1:0] KEEP_ALL = {KW{1'b1}};
  localparam logic [KW-1:0] KEEP_LO  = {{UNITS{1'b0}}, {UNITS{1'b1}}};

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [BW-1:0] data;
  } entry_t;

  typedef enum logic {H_EMPTY, H_PEND} hold_t;

  // ---------------- input classification ----------------
  logic          accept;
  logic          is_half;
  logic [HW-1:0] lo_half;
  logic [BW-1:0] beat_flat;
  logic [HW-1:0] lo;
  logic [HW-1:0] hi;

  assign accept    = s_valid && clken;
  assign beat_flat = s_data_uc;
  assign hi        = beat_flat[BW-1:HW];
  assign lo        = is_half ? lo_half : beat_flat[HW-1:0];

  // Detect a half beat (copy 0 kept, copy 1 dropped in every unit) and gather its copy-0 words
  always_comb begin
    is_half = 1'b1;
    lo_half = '0;
    for (int u = 0; u < UNITS; u++) begin
      if (!(s_keep_uc[u][0] && !s_keep_uc[u][1])) is_half = 1'b0;
      lo_half[u*WORD_WIDTH +: WORD_WIDTH] = s_data_uc[u][0];
    end
  end

  // ---------------- packer ----------------
  hold_t         h, h_nxt;
  logic [HW-1:0] pend, pend_nxt;
  logic          wr0_req, wr1_req;
  entry_t        w0, w1;

  // Decide the next pending half and which packed beats to write this cycle
  always_comb begin
    // NOTE: every signal gets a default first, so a case arm that forgets one cannot infer a latch.
    h_nxt    = h;
    pend_nxt = pend;
    wr0_req  = 1'b0;
    wr1_req  = 1'b0;
    w0       = '0;
    w1       = '0;
    if (accept) begin
      unique case ({h, is_half})
        {H_EMPTY, 1'b1}: begin
          if (s_last) begin
            wr0_req = 1'b1;
            w0.data = {{HW{1'b0}}, lo};
            w0.keep = KEEP_LO;
            w0.last = 1'b1;
          end else begin
            pend_nxt = lo;
            h_nxt    = H_PEND;
          end
        end
        {H_EMPTY, 1'b0}: begin
          wr0_req = 1'b1;
          w0.data = {hi, lo};
          w0.keep = KEEP_ALL;
          w0.last = s_last;
        end
        {H_PEND, 1'b1}: begin
          wr0_req = 1'b1;
          w0.data = {lo, pend};
          w0.keep = KEEP_ALL;
          w0.last = s_last;
          h_nxt   = H_EMPTY;
        end
        default: begin  // pending half plus a full beat: the full beat straddles two outputs
          wr0_req = 1'b1;
          w0.data = {lo, pend};
          w0.keep = KEEP_ALL;
          w0.last = 1'b0;
          if (s_last) begin
            wr1_req = 1'b1;
            w1.data = {{HW{1'b0}}, hi};
            w1.keep = KEEP_LO;
            w1.last = 1'b1;
            h_nxt   = H_EMPTY;
          end else begin
            pend_nxt = hi;
            h_nxt    = H_PEND;
          end
        end
      endcase
    end
  end

  // Packer state: pending-half flag and the held half
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h    <= H_EMPTY;
      pend <= '0;
    end else if (clken) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      h    <= h_nxt;
      pend <= pend_nxt;
    end
  end

  // ---------------- FIFO ----------------
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr1;
  logic [CW-1:0] count, count_nxt;
  logic [CW:0]   free;
  logic          pop, wr0_ok, wr1_ok;
  logic [1:0]    n_wr;
  entry_t        head;

  assign head    = mem[rd_ptr];
  assign m_valid = (count != '0);
  assign m_data  = m_valid ? head.data : '0;
  assign m_keep  = m_valid ? head.keep : '0;
  assign m_last  = m_valid && head.last;
  assign wr_ptr1 = wr_ptr + AW'(1);

  // Admit the writes in order, counting a same-cycle pop as a free slot
  always_comb begin
    pop       = m_valid && m_ready && clken;
    free      = (CW+1)'(DEPTH) - (CW+1)'(count) + (CW+1)'(pop);
    wr0_ok    = wr0_req && (free >= (CW+1)'(1));
    wr1_ok    = wr1_req && (free >= (CW+1)'(2));
    n_wr      = 2'(wr0_ok) + 2'(wr1_ok);
    count_nxt = count + CW'(n_wr) - CW'(pop);
  end

  // Storage array: the first write lands at wr_ptr and the second at the slot after it
  // NOTE: the storage is not reset; the head is masked by m_valid, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (clken) begin
      if (wr0_ok) mem[wr_ptr]  <= w0;
      if (wr1_ok) mem[wr_ptr1] <= w1;
    end
  end

  // Pointers, occupancy and the registered almost-full flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      s_almost_full <= 1'b0;
    end else if (clken) begin
      wr_ptr        <= wr_ptr + AW'(n_wr);
      rd_ptr        <= rd_ptr + AW'(pop);
      count         <= count_nxt;
      s_almost_full <= (count_nxt >= CW'(DEPTH - AF_MARGIN));
    end
  end

`ifdef MAXPOOL_OUT_PACKER_OVERFLOW_EN
  logic [1:0] drops;
  logic [7:0] drop_count;
  logic [8:0] drop_sum;
  logic       overflow_q;

  assign drops    = 2'(wr0_req && !wr0_ok) + 2'(wr1_req && !wr1_ok);
  assign drop_sum = {1'b0, drop_count} + 9'(drops);
  assign overflow = overflow_q;

  // Sticky overflow flag and a drop counter that saturates at 255
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
      drop_count <= '0;
    end else if (clken && (drops != 2'd0)) begin
      overflow_q <= 1'b1;
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_maxpool_out_packer.sv
// Directed bench for maxpool_out_packer with UNITS=2, DEPTH=8, AF_MARGIN=3.
// The bench drives inputs one time unit after the rising edge and samples
// outputs at the same point, which is well clear of the next edge.
module tb_maxpool_out_packer;

  localparam int UNITS = 2;
  localparam int WW    = 8;

  logic                            clk = 1'b0;
  logic                            resetn;
  logic                            clken;
  logic                            s_valid;
  logic [UNITS-1:0][1:0][WW-1:0]   s_data_uc;
  logic [UNITS-1:0][1:0]           s_keep_uc;
  logic                            s_last;
  logic                            s_almost_full;
  logic                            m_valid;
  logic                            m_ready;
  logic [2*UNITS*WW-1:0]           m_data;
  logic [2*UNITS-1:0]              m_keep;
  logic                            m_last;
  logic                            overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  maxpool_out_packer #(.UNITS(UNITS), .WORD_WIDTH(WW), .DEPTH(8), .AF_MARGIN(3)) dut (
    .clk(clk), .resetn(resetn), .clken(clken),
    .s_valid(s_valid), .s_data_uc(s_data_uc), .s_keep_uc(s_keep_uc), .s_last(s_last),
    .s_almost_full(s_almost_full),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .overflow(overflow)
  );

  // The expected word for lane k of full beat n is 4n+k+1.
  function automatic logic [31:0] full_words(input int n);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(4*n + k + 1);
    return w;
  endfunction

  // Each stimulus task starts one time unit after a rising edge and returns
  // one time unit after the edge that accepted the beat.
  task automatic send_full(input logic [31:0] w, input logic last);
    s_valid = 1'b1; s_data_uc = w; s_keep_uc = 4'b1111; s_last = last;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_half(input logic [7:0] lo0, input logic [7:0] lo1, input logic last);
    s_valid = 1'b1; s_data_uc = {8'h00, lo1, 8'h00, lo0}; s_keep_uc = 4'b0101; s_last = last;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    n_checks++;
    if ({m_valid, m_last, m_keep, m_data, s_almost_full, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: outputs=%h expected all zero",
               {m_valid, m_last, m_keep, m_data, s_almost_full, overflow});
    end
    // Queue three entries and leave one half pending, then reset mid-stream.
    m_ready = 1'b0;
    for (int n = 0; n < 3; n++) send_full(full_words(n), 1'b0);
    send_half(8'h11, 8'h22, 1'b0);
    n_checks++;
    if (m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prefill: m_valid=%b expected 1", m_valid);
    end
    #2 resetn = 1'b0;
    #2;
    n_checks++;
    if ({m_valid, m_last, m_keep, m_data, s_almost_full, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_midstream: outputs=%h expected all zero",
               {m_valid, m_last, m_keep, m_data, s_almost_full, overflow});
    end
    @(posedge clk); #1 resetn = 1'b1;
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fifo_empty: m_valid=%b expected 0", m_valid);
    end
    // A pending half that survived reset would corrupt this beat.
    m_ready = 1'b1;
    send_full(32'hA4A3A2A1, 1'b1);
    n_checks++;
    if ({m_valid, m_data, m_keep, m_last} !== {1'b1, 32'hA4A3A2A1, 4'b1111, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_clean_beat: got v=%b d=%h k=%b l=%b expected v=1 d=a4a3a2a1 k=1111 l=1",
               m_valid, m_data, m_keep, m_last);
    end
    idle();
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_single_output: m_valid=%b expected 0", m_valid);
    end
  endtask

  task automatic test_full_beats();
    m_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      send_full(full_words(n), (n == 3));
      n_checks++;
      if ({m_valid, m_data, m_keep, m_last} !== {1'b1, full_words(n), 4'b1111, 1'(n == 3)}) begin
        n_fail++;
        $display("FAIL full_beat_%0d: got v=%b d=%h k=%b l=%b expected v=1 d=%h k=1111 l=%b",
                 n, m_valid, m_data, m_keep, m_last, full_words(n), (n == 3));
      end
    end
    idle();
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drained: m_valid=%b expected 0", m_valid);
    end
  endtask

  task automatic test_half_pairing();
    m_ready = 1'b1;
    send_half(8'd1, 8'd2, 1'b0);
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL half_hold: m_valid=%b expected 0", m_valid);
    end
    send_half(8'd3, 8'd4, 1'b1);
    n_checks++;
    if ({m_valid, m_data, m_keep, m_last} !== {1'b1, 32'h04030201, 4'b1111, 1'b1}) begin
      n_fail++;
      $display("FAIL half_pair: got v=%b d=%h k=%b l=%b expected v=1 d=04030201 k=1111 l=1",
               m_valid, m_data, m_keep, m_last);
    end
    idle();
  endtask

  task automatic test_odd_half_last();
    m_ready = 1'b1;
    send_half(8'd5, 8'd6, 1'b1);
    n_checks++;
    if ({m_valid, m_data, m_keep, m_last} !== {1'b1, 32'h00000605, 4'b0011, 1'b1}) begin
      n_fail++;
      $display("FAIL odd_half: got v=%b d=%h k=%b l=%b expected v=1 d=00000605 k=0011 l=1",
               m_valid, m_data, m_keep, m_last);
    end
    idle();
  endtask

  task automatic test_misaligned_full();
    m_ready = 1'b0;
    send_half(8'd1, 8'd2, 1'b0);
    send_full(32'h06050403, 1'b1);
    n_checks++;
    if ({m_valid, m_data, m_keep, m_last} !== {1'b1, 32'h04030201, 4'b1111, 1'b0}) begin
      n_fail++;
      $display("FAIL misaligned_first: got v=%b d=%h k=%b l=%b expected v=1 d=04030201 k=1111 l=0",
               m_valid, m_data, m_keep, m_last);
    end
    m_ready = 1'b1;
    idle();
    n_checks++;
    if ({m_valid, m_data, m_keep, m_last} !== {1'b1, 32'h00000605, 4'b0011, 1'b1}) begin
      n_fail++;
      $display("FAIL misaligned_second: got v=%b d=%h k=%b l=%b expected v=1 d=00000605 k=0011 l=1",
               m_valid, m_data, m_keep, m_last);
    end
    idle();
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_count: m_valid=%b expected 0", m_valid);
    end
  endtask

  task automatic test_clken();
    m_ready = 1'b1;
    clken   = 1'b0;
    send_full(32'hB4B3B2B1, 1'b0);
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clken_no_accept: m_valid=%b expected 0", m_valid);
    end
    clken   = 1'b1;
    m_ready = 1'b0;
    send_full(32'hC4C3C2C1, 1'b1);
    clken   = 1'b0;
    m_ready = 1'b1;
    idle();
    n_checks++;
    if ({m_valid, m_data, m_last} !== {1'b1, 32'hC4C3C2C1, 1'b1}) begin
      n_fail++;
      $display("FAIL clken_no_pop: got v=%b d=%h l=%b expected v=1 d=c4c3c2c1 l=1",
               m_valid, m_data, m_last);
    end
    clken = 1'b1;
    idle();
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clken_pop: m_valid=%b expected 0", m_valid);
    end
  endtask

  task automatic test_back_pressure_overflow();
    m_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      send_full(full_words(n), 1'b0);
      n_checks++;
      if (s_almost_full !== 1'((n + 1) >= 5)) begin
        n_fail++;
        $display("FAIL almost_full_beat_%0d: got %b expected %b", n + 1, s_almost_full, ((n + 1) >= 5));
      end
    end
`ifdef MAXPOOL_OUT_PACKER_OVERFLOW_EN
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flag: got %b expected 1", overflow);
    end
    n_checks++;
    if (dut.drop_count !== 8'd2) begin
      n_fail++;
      $display("FAIL drop_count: got %0d expected 2", dut.drop_count);
    end
`else
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_tied: got %b expected 0", overflow);
    end
`endif
    m_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if ({m_valid, m_data} !== {1'b1, full_words(n)}) begin
        n_fail++;
        $display("FAIL drain_%0d: got v=%b d=%h expected v=1 d=%h", n, m_valid, m_data, full_words(n));
      end
      idle();
    end
    n_checks++;
    if ({m_valid, s_almost_full} !== 2'b00) begin
      n_fail++;
      $display("FAIL drain_empty: got v=%b af=%b expected v=0 af=0", m_valid, s_almost_full);
    end
  endtask

  initial begin
    resetn    = 1'b0;
    clken     = 1'b1;
    s_valid   = 1'b0;
    s_data_uc = '0;
    s_keep_uc = '0;
    s_last    = 1'b0;
    m_ready   = 1'b0;
    test_reset();
    test_full_beats();
    test_half_pairing();
    test_odd_half_last();
    test_misaligned_full();
    test_clken();
    test_back_pressure_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool_out_packer.md
Name: maxpool_out_packer

Overview:
- Sits directly downstream of the maxpool core and consumes its per-unit, two-copy output beats (valid, data, keep, last).
- Each input beat is one of two kinds:
  - full: all 2*UNITS words kept.
  - half: only copy 0 kept, UNITS words.
- Compacts these into dense 2*UNITS-word output beats with no holes, honouring last.
- The core has no back-pressure, so the block buffers packed beats in a FIFO with an AXI-stream master port and raises almost-full for the controller to drop upstream clken.

Parameters:
- UNITS, 8: units per input beat; output beat = 2*UNITS words.
- WORD_WIDTH, 8: bits per word, signed.
- DEPTH, 8: output FIFO entries (power of 2, >=4).
- AF_MARGIN, 3: s_almost_full high when free entries <= AF_MARGIN (>=2).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- clken  in  1  global clock enable; all state updates and both handshakes are gated by it
- s_valid  in  1  input beat valid
- s_data_uc  in  [UNITS][2] x WORD_WIDTH  input words, lane index = 2*u+c
- s_keep_uc  in  [UNITS][2] x 1  keep per word
- s_last  in  1  end of packet
- s_almost_full  out  1  FIFO free entries <= AF_MARGIN
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_data  out  2*UNITS*WORD_WIDTH  packed words, word k at bits [k*WORD_WIDTH +: WORD_WIDTH]
- m_keep  out  2*UNITS  per-word keep
- m_last  out  1  end of packet
- overflow  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (async, resetn=0):
  - m_valid=0, m_last=0, m_keep=0, m_data=0, s_almost_full=0, overflow=0.
  - FIFO empty, pending register cleared, occupancy h=0.
- Input is always accepted. There is no s_ready. A beat is taken when s_valid && clken.
- Beat classification:
  - full: all keep=1.
  - half: keep[u][0]=1 and keep[u][1]=0 for all u.
  - Any other pattern is treated as full and is not a supported input.
- Half beat words: lo = {s_data_uc[UNITS-1][0] .. s_data_uc[0][0]}, UNITS words in unit order.
- Full beat words: lo = words of units 0..UNITS/2-1 (both copies), hi = words of units UNITS/2..UNITS-1, in lane order. Each half is UNITS words.
- Packer state: h in {0,1} (one pending UNITS-word half held) and a PEND register. Transitions per accepted beat:
  - h=0, half, !last: PEND=lo, h=1. No write.
  - h=0, half, last: write {0,lo}, keep upper UNITS=0, last=1. h=0.
  - h=0, full: write {hi,lo}, keep all 1, last=s_last. h=0.
  - h=1, half: write {lo,PEND}, keep all 1, last=s_last. h=0.
  - h=1, full, !last: write {lo,PEND}, last=0. PEND=hi, h=1.
  - h=1, full, last: two writes in the same cycle:
    - first {lo,PEND}, last=0;
    - then {0,hi}, upper keep=0, last=1.
    - h=0.
- FIFO:
  - Register-based, 2 write ports (in order), 1 read port, occupancy counter 0..DEPTH, pointers wrap modulo DEPTH.
  - Writes land at the clock edge that accepts the input beat.
  - First-word fall-through: m_valid goes high the cycle after that edge.
  - Latency from the accepting edge to m_valid is 1 cycle with the FIFO empty.
- Output handshake: m_valid && m_ready && clken pops one entry.
  - m_data, m_keep, m_last remain stable while m_valid && !m_ready.
  - Simultaneous pop and 1 or 2 writes are allowed. Occupancy += writes - pop.
- s_almost_full is registered and reflects occupancy after the current edge.
- Full boundary: a write with no free entry (after counting a same-cycle pop) is dropped; the entry is not overwritten.
- clken=0: no state changes, no pop. Outputs hold.

Optional Feature:
- Macro: MAXPOOL_OUT_PACKER_OVERFLOW_EN.
- With the macro defined: overflow is set on any dropped write and stays set until resetn. An additional counter saturates at 255 and is readable hierarchically as drop_count.
- Without the macro: overflow is tied to 0 and no drop logic exists. Writes to a full FIFO are still discarded.

Test Plan:
- Reset: UNITS=2, DEPTH=8.
  - Assert resetn=0 mid-stream with 3 entries queued and h=1 -> next cycle all outputs 0, FIFO empty.
  - After release, a single full beat -> one clean output.
- Full beats: 4 full beats data 1..4 (words k+4n), last on the 4th, m_ready=1 -> 4 outputs, keep=4'b1111, m_last only on the 4th, each 1 cycle after its input.
- Half pairing: half beats lo={1,2}, {3,4}, last on the 2nd -> single output {4,3,2,1}, keep 1111, last=1.
- Odd half with last: half {5,6} last, h=0 -> output {0,0,6,5}, keep 0011, last=1.
- Misaligned full: half {1,2}, then full {3,4,5,6} last -> two outputs in order:
  - {4,3,2,1} last=0;
  - {0,0,6,5} keep 0011, last=1.
  - Both written in one cycle.
- Back-pressure and overflow: m_ready=0, 10 full beats, DEPTH=8, AF_MARGIN=3.
  - s_almost_full rises after the 5th beat.
  - 2 writes dropped, overflow=1 with the macro.
  - Draining yields exactly the first 8 beats, in order.
